ramp_adc_capture: RTL

- Conversion back-end for the PWM-sawtooth ramp ADC; sits directly downstream of the ramp generator.
- Synchronises the external comparator output.
- Latches the ramp code at the comparator trip point once per ramp period.
- Flags under/over-range and presents each result on a valid/ready interface to the display/UART consumers.

---
 rtl/ramp_adc_capture.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ramp_adc_capture.sv
// ramp_adc_capture
//   Conversion back-end for the PWM-sawtooth ramp ADC. Synchronises the
//   asynchronous comparator output, latches the ramp code at the comparator
//   trip point once per ramp period, flags under/over-range and presents each
//   result on a valid/ready interface. A result that arrives while an
//   unaccepted one is still held is dropped and sets the sticky overrun flag.
//
//   Optional build macro: RAMP_CAPTURE_AVG_EN
//     When defined, 2^AVG_LOG2 consecutive results are summed, and their
//     truncated mean (with OR'd flags) is what reaches the result register.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   conversion enable; low parks the FSM in IDLE
//   comp_in    in   asynchronous comparator (high while ramp < input)
//   ramp_code  in   current ramp duty code [WIDTH]
//   ramp_wrap  in   one-cycle pulse when the ramp returns to 0
//   res_data   out  conversion result [WIDTH]
//   res_under  out  result was underrange
//   res_over   out  result was overrange
//   res_valid  out  result register holds an unaccepted result
//   res_ready  in   consumer accepts the result
//   overrun    out  sticky: a result was dropped
module ramp_adc_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             comp_in,
  input  logic [WIDTH-1:0] ramp_code,
  input  logic             ramp_wrap,
  output logic [WIDTH-1:0] res_data,
  output logic             res_under,
  output logic             res_over,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun
);

  // Elaboration-time guard on the legal parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_param
    $error("ramp_adc_capture: SYNC_STAGES must be 2..4 and AVG_LOG2 0..6");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ARMED,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Comparator synchroniser and falling-edge detect. Flops reset to 1 so that
  // leaving reset never looks like a comparator trip.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_d_q;
  logic                   comp_s;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '1;
      comp_d_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], comp_in};
      comp_d_q <= comp_s;
    end
  end

  assign comp_s = sync_q[SYNC_STAGES-1];
  assign fall   = ~comp_s & comp_d_q;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             prod_v;
  logic [WIDTH-1:0] prod_code;
  logic             prod_under;
  logic             prod_over;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    prod_v     = 1'b0;
    prod_code  = '0;
    prod_under = 1'b0;
    prod_over  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ramp_wrap) state_d = S_START;
        end
        S_START: begin
          // Comparator already low at the ramp start: input below code 0.
          if (!comp_s) begin
            prod_v     = 1'b1;
            prod_under = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          // A trip coinciding with the wrap still counts as a real code.
          if (fall) begin
            prod_v    = 1'b1;
            prod_code = ramp_code;
            state_d   = ramp_wrap ? S_START : S_DONE;
          end else if (ramp_wrap) begin
            prod_v    = 1'b1;
            prod_code = '1;
            prod_over = 1'b1;
            state_d   = S_START;
          end
        end
        S_DONE: begin
          if (ramp_wrap) state_d = S_START;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load request into the result register
  // ---------------------------------------------------------------------------
  logic             load_v;
  logic [WIDTH-1:0] load_data;
  logic             load_under;
  logic             load_over;

`ifdef RAMP_CAPTURE_AVG_EN
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accu_q, accu_d;
  logic          acco_q, acco_d;
  logic [AW-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      accu_q <= 1'b0;
      acco_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      accu_q <= accu_d;
      acco_q <= acco_d;
    end
  end

  // The last result of a window is folded in combinationally so the mean is
  // loaded on the same edge a direct result would be.
  always_comb begin
    sum        = acc_q + AW'(prod_code);
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    accu_d     = accu_q;
    acco_d     = acco_q;
    load_v     = 1'b0;
    load_data  = '0;
    load_under = 1'b0;
    load_over  = 1'b0;
    if (!enable) begin
      acc_d  = '0;
      cnt_d  = '0;
      accu_d = 1'b0;
      acco_d = 1'b0;
    end else if (prod_v) begin
      if (cnt_q == CNT_LAST) begin
        load_v     = 1'b1;
        load_data  = WIDTH'(sum >> AVG_LOG2);
        load_under = accu_q | prod_under;
        load_over  = acco_q | prod_over;
        acc_d      = '0;
        cnt_d      = '0;
        accu_d     = 1'b0;
        acco_d     = 1'b0;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_q + 1'b1;
        accu_d = accu_q | prod_under;
        acco_d = acco_q | prod_over;
      end
    end
  end
`else
  always_comb begin
    load_v     = prod_v;
    load_data  = prod_code;
    load_under = prod_under;
    load_over  = prod_over;
  end
`endif

  // ---------------------------------------------------------------------------
  // Result register and valid/ready handshake
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] res_data_q;
  logic             res_under_q;
  logic             res_over_q;
  logic             res_valid_q;
  logic             overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_q  <= '0;
      res_under_q <= 1'b0;
      res_over_q  <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (load_v) begin
      // Space exists if empty or the held result is leaving this cycle.
      if (!res_valid_q || res_ready) begin
        res_data_q  <= load_data;
        res_under_q <= load_under;
        res_over_q  <= load_over;
        res_valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_data  = res_data_q;
  assign res_under = res_under_q;
  assign res_over  = res_over_q;
  assign res_valid = res_valid_q;
  assign overrun   = overrun_q;

endmodule
